// File: rtl/avalon_mm_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mm_req_arbiter
// Brief    : Round-robin IF/DM arbiter onto one Avalon-MM bridge slave port;
//            single outstanding transfer with a read-completion timeout.
// Revision : 1.0
// ============================================================================
module avalon_mm_req_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                if_req,
    input  logic                if_we,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic [DATA_W-1:0]   if_wdata,
    input  logic [DATA_W/8-1:0] if_be,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_err,
    output logic [ADDR_W-1:0]   av_address,
    output logic                av_read,
    output logic                av_write,
    output logic [DATA_W-1:0]   av_writedata,
    output logic [DATA_W/8-1:0] av_byteenable,
    output logic                av_burstcount,
    input  logic                av_waitrequest,
    input  logic [DATA_W-1:0]   av_readdata,
    input  logic                av_readdatavalid,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TMO_CYC - 1);
    localparam logic             c_own_if   = 1'b0;
    localparam logic             c_own_dm   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CMD    = 2'd1,
        S_RDWAIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic                r_owner, w_owner;
    logic                r_last_grant, w_last_grant;
    logic                r_we, w_we;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [ADDR_W-1:0]   r_address, w_address;
    logic                r_read, w_read;
    logic                r_write, w_write;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [BE_W-1:0]     r_be, w_be;
    logic                r_if_done, w_if_done;
    logic                r_dm_done, w_dm_done;
    logic                r_if_err, w_if_err;
    logic                r_dm_err, w_dm_err;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata;
    logic                r_busy, w_busy;

    logic                w_pick_dm;
    logic                w_rsp_valid;
    logic                w_rsp_rd;
    logic                w_rsp_err;
    logic [DATA_W-1:0]   w_rsp_data;

    // On a tie the requester that did not win last time gets the bus.
    assign w_pick_dm = dm_req && (!if_req || (r_last_grant == c_own_if));

    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_grant = r_last_grant;
        w_we         = r_we;
        w_cnt        = r_cnt;
        w_address    = r_address;
        w_read       = r_read;
        w_write      = r_write;
        w_wdata      = r_wdata;
        w_be         = r_be;
        w_if_done    = 1'b0;
        w_dm_done    = 1'b0;
        w_if_err     = 1'b0;
        w_dm_err     = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_dm_rdata   = r_dm_rdata;
        w_rsp_valid  = 1'b0;
        w_rsp_rd     = 1'b0;
        w_rsp_err    = 1'b0;
        w_rsp_data   = '0;

        case (r_state)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    w_owner   = w_pick_dm ? c_own_dm : c_own_if;
                    w_we      = w_pick_dm ? dm_we    : if_we;
                    w_address = w_pick_dm ? dm_addr  : if_addr;
                    w_wdata   = w_pick_dm ? dm_wdata : if_wdata;
                    w_be      = w_pick_dm ? dm_be    : if_be;
                    w_read    = !w_we;
                    w_write   = w_we;
                    w_state   = S_CMD;
                end
            end
            S_CMD: begin
                if (!av_waitrequest) begin
                    w_read  = 1'b0;
                    w_write = 1'b0;
                    if (r_we) begin
                        w_rsp_valid = 1'b1;
                    end else if (av_readdatavalid) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_rd    = 1'b1;
                        w_rsp_data  = av_readdata;
                    end else begin
                        w_cnt   = '0;
                        w_state = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                if (av_readdatavalid) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rd    = 1'b1;
                    w_rsp_data  = av_readdata;
                end else if (r_cnt == c_tmo_last) begin
                    // Hung slave: complete with error and zeroed data.
                    w_rsp_valid = 1'b1;
                    w_rsp_rd    = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_last_grant = r_owner;
                w_state      = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_rsp_valid) begin
            w_state = S_RESP;
            if (r_owner == c_own_dm) begin
                w_dm_done = 1'b1;
                w_dm_err  = w_rsp_err;
                if (w_rsp_rd) w_dm_rdata = w_rsp_data;
            end else begin
                w_if_done = 1'b1;
                w_if_err  = w_rsp_err;
                if (w_rsp_rd) w_if_rdata = w_rsp_data;
            end
        end

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state      <= S_IDLE;
            r_owner      <= c_own_if;
            r_last_grant <= c_own_dm;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_if_done    <= 1'b0;
            r_dm_done    <= 1'b0;
            r_if_err     <= 1'b0;
            r_dm_err     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_grant <= w_last_grant;
            r_we         <= w_we;
            r_cnt        <= w_cnt;
            r_address    <= w_address;
            r_read       <= w_read;
            r_write      <= w_write;
            r_wdata      <= w_wdata;
            r_be         <= w_be;
            r_if_done    <= w_if_done;
            r_dm_done    <= w_dm_done;
            r_if_err     <= w_if_err;
            r_dm_err     <= w_dm_err;
            r_if_rdata   <= w_if_rdata;
            r_dm_rdata   <= w_dm_rdata;
            r_busy       <= w_busy;
        end
    end

    assign if_done       = r_if_done;
    assign if_err        = r_if_err;
    assign if_rdata      = r_if_rdata;
    assign dm_done       = r_dm_done;
    assign dm_err        = r_dm_err;
    assign dm_rdata      = r_dm_rdata;
    assign av_address    = r_address;
    assign av_read       = r_read;
    assign av_write      = r_write;
    assign av_writedata  = r_wdata;
    assign av_byteenable = r_be;
    assign av_burstcount = 1'b1;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_avalon_mm_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mm_req_arbiter
// Brief    : Directed and randomized self-checking bench for the IF/DM arbiter.
// Revision : 1.0
// ============================================================================
module tb_avalon_mm_req_arbiter;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        if_req, if_we, dm_req, dm_we;
    logic [27:0] if_addr, dm_addr;
    logic [31:0] if_wdata, dm_wdata;
    logic [3:0]  if_be, dm_be;
    logic        if_done, dm_done, if_err, dm_err;
    logic [31:0] if_rdata, dm_rdata;
    logic [27:0] av_address;
    logic        av_read, av_write, av_burstcount;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest, av_readdatavalid;
    logic [31:0] av_readdata;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_rd [2];   // last read data seen by each requester (0 = IF, 1 = DM)
    int          m_last;     // last granted requester (0 = IF, 1 = DM)

    typedef struct {
        int          cmd;
        int          done;
        int          which;
        int          act;
        bit          stable;
        logic        err;
        logic        we;
        logic [31:0] rdata;
        logic [27:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obs_t;

    avalon_mm_req_arbiter #(.ADDR_W(28), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk_clk(clk), .reset_reset(reset_reset),
        .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata), .if_be(if_be),
        .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable), .av_burstcount(av_burstcount),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected cycles from command to done: waits, then write 1 / read 1 + rdv delay capped by timeout.
    function automatic int exp_lat(input int w, input logic we, input int d);
        if (we) return 1 + w;
        return 1 + w + ((d < 0 || d > TMO) ? TMO : d);
    endfunction

    function automatic logic exp_tmo(input logic we, input int d);
        return !we && (d < 0 || d > TMO);
    endfunction

    task automatic clear_inputs();
        if_req = 0; if_we = 0; if_addr = '0; if_wdata = '0; if_be = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        av_waitrequest = 0; av_readdatavalid = 0; av_readdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        reset_reset = 1;
        repeat (2) @(negedge clk);
        reset_reset = 0;
        m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
    endtask

    // Slave responder and observer: requests are set by the caller in cycle 0.
    // The slave waits w cycles, then returns read data d cycles after accept (d<0: never).
    task automatic serve(input int w, input int d, input logic [31:0] rd, output obs_t o);
        int cyc;
        int acc;
        cyc = 0;
        o = '{cmd: -1, done: -1, which: 0, act: 0, stable: 1'b1, err: 1'b0, we: 1'b0,
              rdata: '0, addr: '0, wdata: '0, be: '0};
        while (o.cmd < 0 && cyc < 12) begin
            @(negedge clk); cyc++;
            if (av_read || av_write) o.cmd = cyc;
        end
        if (o.cmd < 0) return;
        o.addr = av_address; o.we = av_write; o.wdata = av_writedata; o.be = av_byteenable;
        acc = o.cmd + w;
        while (o.done < 0 && cyc < acc + TMO + 20) begin
            if (av_read || av_write) begin
                o.act++;
                if (av_address !== o.addr || av_write !== o.we || av_read !== !o.we ||
                    av_writedata !== o.wdata || av_byteenable !== o.be) o.stable = 0;
            end
            if (if_done || dm_done) begin
                o.done  = cyc;
                o.which = (dm_done ? 2 : 0) + (if_done ? 1 : 0);
                o.rdata = if_done ? if_rdata : dm_rdata;
                o.err   = if_done ? if_err : dm_err;
                if (if_done) if_req = 0;
                if (dm_done) dm_req = 0;
            end else begin
                av_waitrequest   = (cyc < acc);
                av_readdatavalid = (d >= 0) && (cyc == acc + d);
                av_readdata      = av_readdatavalid ? rd : $urandom;
                @(negedge clk); cyc++;
            end
        end
        av_waitrequest = 0; av_readdatavalid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_reset = 1;
        repeat (2) @(negedge clk);
        total++; if ({if_done, dm_done, if_err, dm_err, av_read, av_write, busy} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0", {if_done, dm_done, if_err, dm_err, av_read, av_write, busy}); end
        total++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got if=%h dm=%h want=0", if_rdata, dm_rdata); end
        total++; if (av_address !== 28'h0 || av_writedata !== 32'h0 || av_byteenable !== 4'h0) begin
            bad++; $display("FAIL reset_av got addr=%h wd=%h be=%h want=0", av_address, av_writedata, av_byteenable); end
        total++; if (av_burstcount !== 1'b1) begin
            bad++; $display("FAIL reset_burstcount got=%b want=1", av_burstcount); end
        reset_reset = 0;
        m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || av_read !== 1'b0) begin
            bad++; $display("FAIL reset_idle got busy=%b rd=%b want=0", busy, av_read); end
    endtask

    task automatic test_single_read();
        obs_t        o;
        logic [27:0] a;
        a = 28'($urandom);
        @(negedge clk);
        if_req = 1; if_we = 0; if_addr = a; if_be = 4'hF; if_wdata = $urandom;
        serve(0, 1, 32'h0000_0013, o);
        total++; if (o.cmd !== 1) begin bad++; $display("FAIL rd1_cmd_cycle got=%0d want=1", o.cmd); end
        total++; if (o.act !== 1) begin bad++; $display("FAIL rd1_av_read_cycles got=%0d want=1", o.act); end
        total++; if (o.done !== 3) begin bad++; $display("FAIL rd1_done_cycle got=%0d want=3", o.done); end
        total++; if (o.which !== 1) begin bad++; $display("FAIL rd1_owner got=%0d want=1", o.which); end
        total++; if (o.rdata !== 32'h13 || o.err !== 1'b0) begin
            bad++; $display("FAIL rd1_data got=%h err=%b want=13 err=0", o.rdata, o.err); end
        total++; if (o.addr !== a || o.we !== 1'b0) begin
            bad++; $display("FAIL rd1_cmd got addr=%h we=%b want addr=%h we=0", o.addr, o.we, a); end
        m_rd[0] = 32'h13; m_last = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (dm_done !== 1'b0 || if_done !== 1'b0) begin
                bad++; $display("FAIL rd1_no_extra_done got if=%b dm=%b want=0", if_done, dm_done); end
        end
    endtask

    task automatic test_arbitration();
        obs_t        o;
        logic [31:0] rd_if, rd_dm;
        logic [27:0] ai, ad;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            ai = 28'h0000A00 + 28'(r); ad = 28'h0000B00 + 28'(r);
            rd_if = $urandom; rd_dm = $urandom;
            @(negedge clk);
            if_req = 1; if_we = 0; if_addr = ai; if_be = 4'hF;
            dm_req = 1; dm_we = 0; dm_addr = ad; dm_be = 4'hF;
            serve(0, 0, rd_if, o);
            total++; if (o.which !== 1 || o.addr !== ai || o.cmd !== 1) begin
                bad++; $display("FAIL arb_first_%0d got owner=%0d addr=%h cmd=%0d want owner=1 addr=%h cmd=1", r, o.which, o.addr, o.cmd, ai); end
            total++; if (o.rdata !== rd_if) begin
                bad++; $display("FAIL arb_if_rdata_%0d got=%h want=%h", r, o.rdata, rd_if); end
            serve(0, 0, rd_dm, o);
            total++; if (o.which !== 2 || o.addr !== ad) begin
                bad++; $display("FAIL arb_second_%0d got owner=%0d addr=%h want owner=2 addr=%h", r, o.which, o.addr, ad); end
            total++; if (o.cmd !== 2) begin
                bad++; $display("FAIL arb_b2b_cmd_%0d got=%0d want=2", r, o.cmd); end
            total++; if (o.rdata !== rd_dm) begin
                bad++; $display("FAIL arb_dm_rdata_%0d got=%h want=%h", r, o.rdata, rd_dm); end
            m_rd[0] = rd_if; m_rd[1] = rd_dm; m_last = 1;
        end
    endtask

    task automatic test_write_waitrequest();
        obs_t        o;
        logic [31:0] rd;
        rd = $urandom;
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 28'($urandom); dm_be = 4'hF;
        serve(0, 0, rd, o);
        total++; if (o.which !== 2 || o.rdata !== rd) begin
            bad++; $display("FAIL wr_pre_read got owner=%0d data=%h want owner=2 data=%h", o.which, o.rdata, rd); end
        m_rd[1] = rd; m_last = 1;
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 28'h0000100; dm_wdata = 32'hCAFEBABE; dm_be = 4'b0011;
        serve(3, -1, 32'h0, o);
        total++; if (o.addr !== 28'h0000100 || o.wdata !== 32'hCAFEBABE || o.be !== 4'b0011 || o.we !== 1'b1) begin
            bad++; $display("FAIL wr_fields got addr=%h wd=%h be=%b we=%b", o.addr, o.wdata, o.be, o.we); end
        total++; if (o.act !== 4) begin bad++; $display("FAIL wr_av_write_cycles got=%0d want=4", o.act); end
        total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL wr_stable got=%b want=1", o.stable); end
        total++; if (o.done !== 5 || o.which !== 2) begin
            bad++; $display("FAIL wr_done got cyc=%0d owner=%0d want cyc=5 owner=2", o.done, o.which); end
        total++; if (o.err !== 1'b0 || dm_rdata !== m_rd[1]) begin
            bad++; $display("FAIL wr_resp got err=%b rdata=%h want err=0 rdata=%h", o.err, dm_rdata, m_rd[1]); end
        @(negedge clk);
        total++; if (dm_done !== 1'b0) begin bad++; $display("FAIL wr_single_done got=%b want=0", dm_done); end
    endtask

    task automatic test_timeout();
        obs_t        o;
        logic [31:0] rd;
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 28'($urandom); dm_be = 4'hF;
        serve(0, -1, 32'h0, o);
        total++; if (o.done !== 2 + TMO || o.which !== 2) begin
            bad++; $display("FAIL tmo_done got cyc=%0d owner=%0d want cyc=%0d owner=2", o.done, o.which, 2 + TMO); end
        total++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
            bad++; $display("FAIL tmo_resp got err=%b rdata=%h want err=1 rdata=0", o.err, o.rdata); end
        m_rd[1] = '0; m_last = 1;
        rd = $urandom;
        @(negedge clk);
        if_req = 1; if_we = 0; if_addr = 28'($urandom); if_be = 4'hF;
        serve(0, 2, rd, o);
        total++; if (o.done !== 4 || o.which !== 1 || o.err !== 1'b0 || o.rdata !== rd) begin
            bad++; $display("FAIL tmo_next got cyc=%0d owner=%0d err=%b data=%h want 4/1/0/%h", o.done, o.which, o.err, o.rdata, rd); end
        m_rd[0] = rd; m_last = 0;
    endtask

    task automatic test_reset_in_rdwait();
        @(negedge clk);
        if_req = 1; if_we = 0; if_addr = 28'($urandom); if_be = 4'hF;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1 || av_read !== 1'b0) begin
            bad++; $display("FAIL rst_rdwait_entry got busy=%b rd=%b want busy=1 rd=0", busy, av_read); end
        #2 reset_reset = 1;
        #1;
        total++; if ({busy, if_done, dm_done, av_read, av_write, if_err, dm_err} !== 7'b0 ||
                     if_rdata !== 32'h0 || dm_rdata !== 32'h0 || av_address !== 28'h0) begin
            bad++; $display("FAIL rst_async got ctl=%b if_rd=%h dm_rd=%h addr=%h want 0",
                {busy, if_done, dm_done, av_read, av_write, if_err, dm_err}, if_rdata, dm_rdata, av_address); end
        if_req = 0;
        @(negedge clk);
        reset_reset = 0;
        m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
        av_readdatavalid = 1; av_readdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            av_readdatavalid = 0;
            total++; if (if_done !== 1'b0 || dm_done !== 1'b0 || if_rdata !== 32'h0 || busy !== 1'b0) begin
                bad++; $display("FAIL rst_late_rdv got done=%b%b rdata=%h busy=%b want 0", if_done, dm_done, if_rdata, busy); end
        end
    endtask

    task automatic test_stray_rdv();
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (if_done !== 1'b0 || dm_done !== 1'b0 || busy !== 1'b0 ||
                         if_rdata !== m_rd[0] || dm_rdata !== m_rd[1]) begin
                bad++; $display("FAIL stray_idle got done=%b%b busy=%b if_rd=%h dm_rd=%h", if_done, dm_done, busy, if_rdata, dm_rdata); end
            av_readdatavalid = (i < 3); av_readdata = $urandom;
        end
        av_readdatavalid = 0;
        for (int w = 0; w < 3; w += 2) begin
            @(negedge clk);
            dm_req = 1; dm_we = 1; dm_addr = 28'($urandom); dm_wdata = $urandom; dm_be = 4'($urandom);
            serve(w, 0, $urandom, o);
            total++; if (o.which !== 2 || o.done !== 2 + w || o.err !== 1'b0 || dm_rdata !== m_rd[1]) begin
                bad++; $display("FAIL stray_write_%0d got owner=%0d cyc=%0d err=%b rdata=%h", w, o.which, o.done, o.err, dm_rdata); end
            m_last = 1;
            av_readdatavalid = 1; av_readdata = $urandom;
            @(negedge clk);
            av_readdatavalid = 0;
            total++; if (if_done !== 1'b0 || dm_done !== 1'b0 || dm_rdata !== m_rd[1] || if_rdata !== m_rd[0]) begin
                bad++; $display("FAIL stray_resp_%0d got done=%b%b dm_rd=%h if_rd=%h", w, if_done, dm_done, dm_rdata, if_rdata); end
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        pi, pd, iwe, dwe, we;
        logic [27:0] ia, da;
        logic [31:0] iwd, dwd, rd, want_rd;
        logic [3:0]  ibe, dbe;
        int          s, win, w, d;
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            pi = 1'($urandom_range(0, 1)); pd = 1'($urandom_range(0, 1));
            if (!pi && !pd) pi = 1;
            ia = 28'($urandom); da = 28'($urandom); iwd = $urandom; dwd = $urandom;
            ibe = 4'($urandom); dbe = 4'($urandom);
            iwe = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
            @(negedge clk);
            if_req = pi; if_we = iwe; if_addr = ia; if_wdata = iwd; if_be = ibe;
            dm_req = pd; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_be = dbe;
            s = 1;
            while (pi || pd) begin
                win = (pi && pd) ? 1 - m_last : (pi ? 0 : 1);
                we  = (win == 1) ? dwe : iwe;
                w   = $urandom_range(0, 3);
                d   = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4);
                rd  = $urandom;
                serve(w, d, rd, o);
                total++; if (o.which !== win + 1 || o.cmd !== s) begin
                    bad++; $display("FAIL rnd_grant_%0d got owner=%0d cmd=%0d want owner=%0d cmd=%0d", it, o.which, o.cmd, win + 1, s); end
                total++; if (o.addr !== ((win == 1) ? da : ia) || o.we !== we || o.stable !== 1'b1) begin
                    bad++; $display("FAIL rnd_cmd_%0d got addr=%h we=%b stable=%b", it, o.addr, o.we, o.stable); end
                if (we) begin
                    total++; if (o.wdata !== ((win == 1) ? dwd : iwd) || o.be !== ((win == 1) ? dbe : ibe)) begin
                        bad++; $display("FAIL rnd_wfields_%0d got wd=%h be=%b", it, o.wdata, o.be); end
                end
                total++; if (o.done !== s + exp_lat(w, we, d)) begin
                    bad++; $display("FAIL rnd_latency_%0d got=%0d want=%0d", it, o.done, s + exp_lat(w, we, d)); end
                want_rd = we ? m_rd[win] : (exp_tmo(we, d) ? 32'h0 : rd);
                total++; if (o.err !== exp_tmo(we, d) || o.rdata !== want_rd) begin
                    bad++; $display("FAIL rnd_resp_%0d got err=%b rdata=%h want err=%b rdata=%h", it, o.err, o.rdata, exp_tmo(we, d), want_rd); end
                m_rd[win] = want_rd;
                m_last = win;
                if (win == 1) pd = 0; else pi = 0;
                s = 2;
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset_reset = 1;
        test_reset();
        test_single_read();
        test_arbitration();
        test_write_waitrequest();
        test_timeout();
        test_reset_in_rdwait();
        test_stray_rdv();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
